change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
Payout side of the vending machine. It takes a change or refund amount from the vending FSM and physically returns it, one coin at a time. Each coin is a one-cycle eject pulse to the coin-tube solenoids, with coins chosen greedily from the 50c, 20c and 10c tubes. The block tracks tube inventory and reports any shortfall when it cannot pay in full.

Parameters:
AMT_W, 8, width of amount fields, in units of 10c
CNT_W, 8, width of each tube coin counter
INIT_N10, 4, 10c tube count after reset
INIT_N20, 4, 20c tube count after reset
INIT_N50, 4, 50c tube count after reset
EJECT_GAP, 2, idle cycles after each eject pulse (solenoid recovery); legal range is 1 or more

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  payout request valid
req_ready  out  1  block can accept a request
req_amount  in  AMT_W  amount to pay out, in units of 10c
refill  in  1  load the tube counts from the refill_n* inputs
refill_n10  in  CNT_W  new 10c count
refill_n20  in  CNT_W  new 20c count
refill_n50  in  CNT_W  new 50c count
coin_eject  out  1  one-cycle solenoid pulse
coin_code  out  2  coin being ejected: 00=10c, 01=20c, 10=50c, 11 is never driven
done  out  1  one-cycle pulse when the payout ends
short  out  1  payout was incomplete; valid with done, held until the next accept
remaining  out  AMT_W  unpaid amount; valid with done, held until the next accept
n10, n20, n50  out  CNT_W  current tube counts

Behaviour:
- Reset (async, asserts immediately):
  - State goes to IDLE.
  - coin_eject=0, coin_code=00, done=0, short=0, remaining=0.
  - n10/n20/n50 load INIT_N10/INIT_N20/INIT_N50.
  - Any payout in progress is abandoned; no further pulses follow.
- States: IDLE, SELECT, EJECT, GAP, DONE.
- IDLE:
  - req_ready = !refill; req_ready is 0 in every other state.
  - If refill=1: the counts load on this edge and no request is accepted this cycle.
  - Else on req_valid && req_ready: latch req_amount into an internal balance and clear short and remaining.
    - If req_amount=0, go to DONE.
    - Otherwise go to SELECT.
  - refill is ignored outside IDLE.
- SELECT (exactly 1 cycle), pick a coin in this priority order:
  - 50c if balance ≥5 and n50>0;
  - else 20c if balance ≥2 and n20>0;
  - else 10c if balance ≥1 and n10>0.
  - If a coin is picked, go to EJECT. If none qualifies, go to DONE.
  - The selection is strictly greedy with no backtracking. Example: balance 6 with n10=0 pays 50c, then ends short with remaining=1.
- EJECT (exactly 1 cycle):
  - coin_eject=1 and coin_code = the selected coin.
  - The chosen tube count decrements by 1; the balance decrements by 5, 2 or 1.
  - Go to GAP.
- GAP: EJECT_GAP cycles with coin_eject=0. Then go to SELECT if balance>0, else DONE.
- Timing:
  - The first eject pulse occurs 2 cycles after the accept edge.
  - Consecutive pulses are exactly EJECT_GAP+2 cycles apart.
- DONE (1 cycle):
  - done=1, remaining=balance, short=(balance!=0). Return to IDLE.
  - short and remaining hold their values after this cycle.
- Arithmetic: counts never underflow, because a coin is only selected when its count is >0. The balance never goes negative, by the selection rule.
- coin_eject and done are registered outputs; they are never high in the same cycle.

Test Plan:
1. Reset with default parameters -> req_ready=1, n10=n20=n50=4, coin_eject=0, done=0, remaining=0.
2. Request amount 3 (30c) -> pulse with code 01 at accept+2, pulse with code 00 at accept+6, done 3 cycles after the second pulse with short=0 and remaining=0; counts end n20=3, n10=3.
3. Request amount 8 (80c) from 4/4/4 -> codes 10, 01, 00 in that order, each pulse 4 cycles apart; done with short=0; counts end n50=3, n20=3, n10=3.
4. Refill with n10=0, n20=1, n50=0, then request amount 3 -> one pulse with code 01, then done with short=1 and remaining=1; n20=0.
5. Request amount 0 -> no eject pulse; done at accept+1 with short=0. Separately, assert refill and req_valid in the same IDLE cycle -> counts load, req_ready=0, request not accepted.
6. Request amount 5 from 4/4/4 with n50 refilled to 0 -> codes 01, 01, 00. Assert reset during the GAP after the first pulse -> outputs clear immediately, counts reload to 4/4/4, no further pulses, and req_ready=1 after reset releases.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin payout engine: pays a requested amount greedily from the 50c/20c/10c tubes,
// one eject pulse at a time, and reports any shortfall.
`timescale 1ns/1ps
module change_dispenser #(
    parameter int AMT_W    = 8,
    parameter int CNT_W    = 8,
    parameter int INIT_N10 = 4,
    parameter int INIT_N20 = 4,
    parameter int INIT_N50 = 4,
    parameter int EJECT_GAP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill_n10,
    input  logic [CNT_W-1:0] refill_n20,
    input  logic [CNT_W-1:0] refill_n50,
    output logic             coin_eject,
    output logic [1:0]       coin_code,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] n10,
    output logic [CNT_W-1:0] n20,
    output logic [CNT_W-1:0] n50
);
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_GAP, S_DONE} state_t;

    localparam int GW = (EJECT_GAP > 1) ? $clog2(EJECT_GAP) : 1;
    localparam logic [1:0]       C10 = 2'b00;
    localparam logic [1:0]       C20 = 2'b01;
    localparam logic [1:0]       C50 = 2'b10;
    localparam logic [AMT_W-1:0] V1  = AMT_W'(1);
    localparam logic [AMT_W-1:0] V2  = AMT_W'(2);
    localparam logic [AMT_W-1:0] V5  = AMT_W'(5);
    localparam logic [AMT_W-1:0] V0  = '0;
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO = '0;

    state_t           r_state;
    logic [AMT_W-1:0] r_balance;
    logic [GW-1:0]    r_gap;
    logic [1:0]       r_code;
    logic             r_eject;
    logic             r_done;
    logic             r_short;
    logic [AMT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_n10, r_n20, r_n50;

    logic             w_sel_any;
    logic [1:0]       w_sel_code;
    logic [AMT_W-1:0] w_code_val;

    // Greedy pick; a tube is only eligible when non-empty, so counts never underflow.
    always_comb begin
        w_sel_any  = 1'b1;
        w_sel_code = C10;
        if (r_balance >= V5 && r_n50 != C_ZERO)
            w_sel_code = C50;
        else if (r_balance >= V2 && r_n20 != C_ZERO)
            w_sel_code = C20;
        else if (r_balance >= V1 && r_n10 != C_ZERO)
            w_sel_code = C10;
        else
            w_sel_any = 1'b0;
    end

    always_comb begin
        case (r_code)
            C50:     w_code_val = V5;
            C20:     w_code_val = V2;
            default: w_code_val = V1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_balance <= '0;
            r_gap     <= '0;
            r_code    <= C10;
            r_eject   <= 1'b0;
            r_done    <= 1'b0;
            r_short   <= 1'b0;
            r_rem     <= '0;
            r_n10     <= CNT_W'(INIT_N10);
            r_n20     <= CNT_W'(INIT_N20);
            r_n50     <= CNT_W'(INIT_N50);
        end else begin
            r_eject <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (refill) begin
                        r_n10 <= refill_n10;
                        r_n20 <= refill_n20;
                        r_n50 <= refill_n50;
                    end else if (req_valid) begin
                        r_balance <= req_amount;
                        r_short   <= 1'b0;
                        r_rem     <= '0;
                        if (req_amount == V0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (w_sel_any) begin
                        r_code  <= w_sel_code;
                        r_eject <= 1'b1;
                        r_state <= S_EJECT;
                    end else begin
                        r_done  <= 1'b1;
                        r_rem   <= r_balance;
                        r_short <= (r_balance != V0);
                        r_state <= S_DONE;
                    end
                end
                S_EJECT: begin
                    case (r_code)
                        C50:     r_n50 <= r_n50 - C_ONE;
                        C20:     r_n20 <= r_n20 - C_ONE;
                        default: r_n10 <= r_n10 - C_ONE;
                    endcase
                    r_balance <= r_balance - w_code_val;
                    r_gap     <= GW'(EJECT_GAP - 1);
                    r_state   <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - GW'(1);
                    end else if (r_balance != V0) begin
                        r_state <= S_SELECT;
                    end else begin
                        r_done  <= 1'b1;
                        r_rem   <= V0;
                        r_short <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE) && !refill;
    assign coin_eject = r_eject;
    assign coin_code  = r_code;
    assign done       = r_done;
    assign short      = r_short;
    assign remaining  = r_rem;
    assign n10        = r_n10;
    assign n20        = r_n20;
    assign n50        = r_n50;
endmodule
